emif_calbus_responder: RTL
==========================

# emif_calbus_responder

Responder end of the EMIF calibration component bus: accepts the read/write/address/wdata strobes issued by the calibration IP on `calbus_clk`, returns 32-bit read data, and drives the 4096-bit sequencer parameter table from a local 128-word RAM. A host-side preload port fills the table before calibration. A small CSR bank exports calibration status and access counters to the rest of the FPGA top.

## Interface
- `TBL_WORDS`, 128: parameter-table depth in 32-bit words; `TBL_WORDS*32` must equal 4096.
- `CNT_W`, 16: width of the saturating access counters.
- `ID_VALUE`, 32'hCA1B_0001: constant returned by the ID CSR.
- `calbus_clk` in 1: the single clock, driven by the calibration IP's calbus clock output.
- `calbus_reset_n` in 1: asynchronous, active-low reset.
- `calbus_read` in 1: read strobe, one access per cycle.
- `calbus_write` in 1: write strobe.
- `calbus_address` in 20: word address.
- `calbus_wdata` in 32: write data.
- `calbus_rdata` out 32: read data, registered.
- `calbus_seq_param_tbl` out 4096: word i on bits [32i+31:32i].
- `host_wr_valid` in 1: preload request.
- `host_wr_ready` out 1: preload accepted when valid && ready.
- `host_wr_idx` in 7: table word index.
- `host_wr_data` in 32: table word.
- `cal_done` out 1: CTRL.done.
- `cal_fail` out 1: CTRL.fail.
- `cal_phase` out 3: FSM state encoding.

## Operation
- Decode on `calbus_address[19:16]`:
  - 0x0 is the table, indexed by addr[6:0]; addr[15:7] must be 0.
  - 0x1 is the CSR bank, indexed by addr[3:0]; addr[15:4] must be 0.
  - Anything else is unmapped.
- CSRs:
  - 0 CTRL (rw): bit0 `tbl_lock`, bit1 `done`, bit2 `fail`, bit3 `cnt_clr`. `cnt_clr` is write-1, self-clearing, and always reads 0.
  - 1 RD_CNT (ro): table reads.
  - 2 WR_CNT (ro): table writes.
  - 3 ERR_CNT (ro): unmapped accesses plus read&write in the same cycle.
  - 4 ID (ro).
  - 5–15 read 0. Writes to ro/reserved CSRs are ignored and not counted as errors.
- Unmapped read returns 32'h0 and increments ERR_CNT; unmapped write has no effect and increments ERR_CNT.
- `calbus_read` and `calbus_write` high together: protocol error. Neither access is performed, rdata holds, ERR_CNT increments.
- Counters saturate at all-ones. `cnt_clr` zeroes all three counters and wins over a same-cycle increment.
- Host preload:
  - `host_wr_ready` = !tbl_lock && !(calbus_write to the table region) && phase ∈ {IDLE, LOADING}.
  - On a same-cycle conflict, the calbus write wins.
- FSM `cal_phase`:
  - IDLE=0 → LOADING=1 on the first accepted host write.
  - IDLE/LOADING → ARMED=2 when a calbus write sets tbl_lock.
  - ARMED → CALIBRATING=3 on the first calbus access of any kind after the lock.
  - CALIBRATING → DONE=4 when CTRL.done is written 1 with fail 0.
  - CALIBRATING → FAIL=5 when fail is written 1; fail wins if done and fail are set together.
  - DONE/FAIL → IDLE when CTRL is written with tbl_lock=0, done=0, fail=0.
  - Clearing tbl_lock from ARMED returns the FSM to LOADING.

## Timing
- Reset values: all table words 0, `calbus_rdata` 0, CTRL 0, counters 0, `cal_phase` IDLE, `cal_done`/`cal_fail` 0, `host_wr_ready` 1.
- Reads: `calbus_read` in cycle N gives `calbus_rdata` valid from N+1 and held until the next valid read. Back-to-back reads are supported every cycle.
- Writes take effect at the end of the strobe cycle.
  - A table write updates `calbus_seq_param_tbl` from N+1.
  - A read of the same word in N+1 returns the new value.
- Host write handshake in cycle N shows on the table output at N+1.
- `cal_done`/`cal_fail` follow CTRL one cycle after the write. `cal_phase` changes one cycle after its trigger.
- Reset asserted mid-operation clears all state immediately, including the table; the host must re-preload.

## Structure
- Package `emif_calbus_pkg` holds:
  - region codes and CSR index constants;
  - the `cal_phase_e` enum;
  - the CTRL bit positions;
  - `ID_VALUE`.
- Sub-module `emif_calbus_sat_cnt`: CNT_W saturating counter with inc/clr, clr priority. It is instantiated three times.
- The table is a flop array, not inferred RAM, because all 4096 bits are read in parallel.

## Test plan
- Reset, then read CSR 4 at address 0x10004 → rdata 0xCA1B0001 one cycle later; every other output at its reset value.
- Host preloads idx 5 = 0x12345678 → `calbus_seq_param_tbl[191:160]` = 0x12345678 next cycle, phase LOADING. Calbus read of 0x00005 → 0x12345678, RD_CNT=1.
- Write CTRL=0x1, host_wr_valid held → ready 0, table unchanged, phase ARMED. Next calbus read moves the phase to CALIBRATING.
- Read and write together, then a read of 0x20000 → ERR_CNT=2, rdata 0. Write CTRL bit3 → all counters 0.
- Calbus write to idx 7 and host write to idx 7 in the same cycle with lock=0 → calbus data stored, host not accepted.
- In CALIBRATING, write CTRL=0x7 → `cal_fail`=1, phase FAIL. Write CTRL=0 → phase IDLE. Assert reset mid-sequence → table all 0.

Source files
------------

// File: rtl/emif_calbus_responder_pkg.sv
// ---------------------------------------------------------------------------
// emif_calbus_pkg
// Shared definitions for the EMIF calibration-bus responder: address region
// codes, CSR indices, CTRL bit positions, the calibration phase encoding and
// the ID constant reported by the ID CSR.
// ---------------------------------------------------------------------------
package emif_calbus_pkg;

    // Region select lives in calbus_address[19:16]
    localparam logic [3:0] REGION_TBL = 4'h0;
    localparam logic [3:0] REGION_CSR = 4'h1;

    // CSR word indices inside the CSR region
    localparam logic [3:0] CSR_CTRL    = 4'd0;
    localparam logic [3:0] CSR_RD_CNT  = 4'd1;
    localparam logic [3:0] CSR_WR_CNT  = 4'd2;
    localparam logic [3:0] CSR_ERR_CNT = 4'd3;
    localparam logic [3:0] CSR_ID      = 4'd4;

    // CTRL register bit positions
    localparam int CTRL_LOCK = 0;
    localparam int CTRL_DONE = 1;
    localparam int CTRL_FAIL = 2;
    localparam int CTRL_CLR  = 3;

    localparam logic [31:0] ID_VALUE = 32'hCA1B_0001;

    typedef enum logic [2:0] {
        PH_IDLE        = 3'd0,
        PH_LOADING     = 3'd1,
        PH_ARMED       = 3'd2,
        PH_CALIBRATING = 3'd3,
        PH_DONE        = 3'd4,
        PH_FAIL        = 3'd5
    } cal_phase_e;

    // Host preload is only meaningful before the table has been handed over
    function automatic logic phase_accepts_preload(cal_phase_e ph);
        return (ph == PH_IDLE) || (ph == PH_LOADING);
    endfunction

endpackage

// File: rtl/emif_calbus_responder_if.sv
// ---------------------------------------------------------------------------
// emif_calbus_responder_if
// Groups the calibration component bus and the host preload handshake.
//   master : calibration IP / host side (drives strobes, address, data)
//   slave  : responder side (returns calbus_rdata and host_wr_ready)
// ---------------------------------------------------------------------------
interface emif_calbus_responder_if;

    logic        calbus_read;
    logic        calbus_write;
    logic [19:0] calbus_address;
    logic [31:0] calbus_wdata;
    logic [31:0] calbus_rdata;

    logic        host_wr_valid;
    logic        host_wr_ready;
    logic [6:0]  host_wr_idx;
    logic [31:0] host_wr_data;

    modport master (
        output calbus_read, calbus_write, calbus_address, calbus_wdata,
        output host_wr_valid, host_wr_idx, host_wr_data,
        input  calbus_rdata, host_wr_ready
    );

    modport slave (
        input  calbus_read, calbus_write, calbus_address, calbus_wdata,
        input  host_wr_valid, host_wr_idx, host_wr_data,
        output calbus_rdata, host_wr_ready
    );

endinterface

// File: rtl/emif_calbus_sat_cnt.sv
// ---------------------------------------------------------------------------
// emif_calbus_sat_cnt
// Saturating up-counter used for the access statistics CSRs.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : count one event (ignored once all-ones is reached)
//   clr        : synchronous clear, takes priority over inc
//   cnt        : current count
// ---------------------------------------------------------------------------
module emif_calbus_sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    // Clear beats increment so a clear is never lost to a coincident event
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/emif_calbus_responder.sv
// ---------------------------------------------------------------------------
// emif_calbus_responder
// Responder end of the EMIF calibration component bus. Serves reads/writes
// to a 128-word parameter table and a small CSR bank, drives the full
// 4096-bit sequencer parameter table, and accepts host preload writes.
//   calbus_clk, calbus_reset_n : clock, asynchronous active-low reset
//   bus                        : calbus strobes/data + host preload handshake
//   calbus_seq_param_tbl       : word i on bits [32i+31:32i]
//   cal_done, cal_fail         : CTRL.done / CTRL.fail
//   cal_phase                  : calibration phase encoding
// ---------------------------------------------------------------------------
module emif_calbus_responder #(
    parameter int          TBL_WORDS = 128,
    parameter int          CNT_W     = 16,
    parameter logic [31:0] ID_VALUE  = emif_calbus_pkg::ID_VALUE
) (
    input  logic                      calbus_clk,
    input  logic                      calbus_reset_n,
    emif_calbus_responder_if.slave    bus,
    output logic [TBL_WORDS*32-1:0]   calbus_seq_param_tbl,
    output logic                      cal_done,
    output logic                      cal_fail,
    output logic [2:0]                cal_phase
);

    import emif_calbus_pkg::*;

    logic [TBL_WORDS*32-1:0] tbl_q;
    logic [31:0]             rdata_q;
    logic [31:0]             csr_rdata;
    logic                    ctrl_lock, ctrl_done, ctrl_fail;
    logic [CNT_W-1:0]        rd_cnt, wr_cnt, err_cnt;
    cal_phase_e              phase_q, phase_d;

    logic [3:0]  region;
    logic [6:0]  tbl_idx;
    logic [3:0]  csr_idx;
    logic        tbl_hit, csr_hit, unmapped;
    logic        rd_req, wr_req, both_req;
    logic        tbl_wr, tbl_rd, ctrl_wr, cnt_clr, err_inc;
    logic        host_ready, host_acc;

    assign region   = bus.calbus_address[19:16];
    assign tbl_idx  = bus.calbus_address[6:0];
    assign csr_idx  = bus.calbus_address[3:0];
    assign tbl_hit  = (region == REGION_TBL) && (bus.calbus_address[15:7] == 9'd0);
    assign csr_hit  = (region == REGION_CSR) && (bus.calbus_address[15:4] == 12'd0);
    assign unmapped = !tbl_hit && !csr_hit;

    // Read and write together is a protocol error: neither side is performed
    assign both_req = bus.calbus_read && bus.calbus_write;
    assign rd_req   = bus.calbus_read && !bus.calbus_write;
    assign wr_req   = bus.calbus_write && !bus.calbus_read;

    assign tbl_wr   = wr_req && tbl_hit;
    assign tbl_rd   = rd_req && tbl_hit;
    assign ctrl_wr  = wr_req && csr_hit && (csr_idx == CSR_CTRL);
    assign cnt_clr  = ctrl_wr && bus.calbus_wdata[CTRL_CLR];
    assign err_inc  = both_req || ((bus.calbus_read || bus.calbus_write) && unmapped);

    // Any calbus write aimed at the table blocks the host, so the bus wins conflicts
    assign host_ready = !ctrl_lock && !(bus.calbus_write && tbl_hit)
                        && phase_accepts_preload(phase_q);
    assign host_acc   = bus.host_wr_valid && host_ready;

    assign bus.host_wr_ready    = host_ready;
    assign bus.calbus_rdata     = rdata_q;
    assign calbus_seq_param_tbl = tbl_q;
    assign cal_done             = ctrl_done;
    assign cal_fail             = ctrl_fail;
    assign cal_phase            = phase_q;

    emif_calbus_sat_cnt #(.CNT_W(CNT_W)) u_rd_cnt (
        .clk(calbus_clk), .rst_n(calbus_reset_n), .inc(tbl_rd), .clr(cnt_clr), .cnt(rd_cnt)
    );
    emif_calbus_sat_cnt #(.CNT_W(CNT_W)) u_wr_cnt (
        .clk(calbus_clk), .rst_n(calbus_reset_n), .inc(tbl_wr), .clr(cnt_clr), .cnt(wr_cnt)
    );
    emif_calbus_sat_cnt #(.CNT_W(CNT_W)) u_err_cnt (
        .clk(calbus_clk), .rst_n(calbus_reset_n), .inc(err_inc), .clr(cnt_clr), .cnt(err_cnt)
    );

    // CSR read mux; the self-clearing cnt_clr bit is never stored so reads 0
    always_comb begin
        csr_rdata = '0;
        case (csr_idx)
            CSR_CTRL:    csr_rdata = {29'd0, ctrl_fail, ctrl_done, ctrl_lock};
            CSR_RD_CNT:  csr_rdata = 32'(rd_cnt);
            CSR_WR_CNT:  csr_rdata = 32'(wr_cnt);
            CSR_ERR_CNT: csr_rdata = 32'(err_cnt);
            CSR_ID:      csr_rdata = ID_VALUE;
            default:     csr_rdata = '0;
        endcase
    end

    // Registered read data, held until the next valid read
    always_ff @(posedge calbus_clk or negedge calbus_reset_n) begin
        if (!calbus_reset_n) begin
            rdata_q <= '0;
        end else if (rd_req) begin
            if (tbl_hit) begin
                rdata_q <= tbl_q[{tbl_idx, 5'd0} +: 32];
            end else if (csr_hit) begin
                rdata_q <= csr_rdata;
            end else begin
                rdata_q <= '0;
            end
        end
    end

    // Parameter table as flops so every word drives the output in parallel
    always_ff @(posedge calbus_clk or negedge calbus_reset_n) begin
        if (!calbus_reset_n) begin
            tbl_q <= '0;
        end else if (tbl_wr) begin
            tbl_q[{tbl_idx, 5'd0} +: 32] <= bus.calbus_wdata;
        end else if (host_acc) begin
            tbl_q[{bus.host_wr_idx, 5'd0} +: 32] <= bus.host_wr_data;
        end
    end

    always_ff @(posedge calbus_clk or negedge calbus_reset_n) begin
        if (!calbus_reset_n) begin
            ctrl_lock <= 1'b0;
            ctrl_done <= 1'b0;
            ctrl_fail <= 1'b0;
        end else if (ctrl_wr) begin
            ctrl_lock <= bus.calbus_wdata[CTRL_LOCK];
            ctrl_done <= bus.calbus_wdata[CTRL_DONE];
            ctrl_fail <= bus.calbus_wdata[CTRL_FAIL];
        end
    end

    always_ff @(posedge calbus_clk or negedge calbus_reset_n) begin
        if (!calbus_reset_n) begin
            phase_q <= PH_IDLE;
        end else begin
            phase_q <= phase_d;
        end
    end

    // Phase transitions; locking beats a same-cycle host preload, and
    // unlocking from ARMED beats the access that would start calibration
    always_comb begin
        phase_d = phase_q;
        case (phase_q)
            PH_IDLE: begin
                if (ctrl_wr && bus.calbus_wdata[CTRL_LOCK]) begin
                    phase_d = PH_ARMED;
                end else if (host_acc) begin
                    phase_d = PH_LOADING;
                end
            end
            PH_LOADING: begin
                if (ctrl_wr && bus.calbus_wdata[CTRL_LOCK]) begin
                    phase_d = PH_ARMED;
                end
            end
            PH_ARMED: begin
                if (ctrl_wr && !bus.calbus_wdata[CTRL_LOCK]) begin
                    phase_d = PH_LOADING;
                end else if (bus.calbus_read || bus.calbus_write) begin
                    phase_d = PH_CALIBRATING;
                end
            end
            PH_CALIBRATING: begin
                if (ctrl_wr && bus.calbus_wdata[CTRL_FAIL]) begin
                    phase_d = PH_FAIL;
                end else if (ctrl_wr && bus.calbus_wdata[CTRL_DONE]) begin
                    phase_d = PH_DONE;
                end
            end
            PH_DONE, PH_FAIL: begin
                if (ctrl_wr && (bus.calbus_wdata[2:0] == 3'b000)) begin
                    phase_d = PH_IDLE;
                end
            end
            default: phase_d = PH_IDLE;
        endcase
    end

endmodule
